rider_sequencer: RTL and testbench
==================================

# rider_sequencer

Rider-detection and steering-enable sequencer for the balance controller. It qualifies the two load-cell readings and produces the `rider_off` and `en_steer` controls consumed by the PID/SegwayMath path. The block is a three-state FSM with a settle timer. It sits between the load-cell A2D interface and `balance_cntrl`, and is gated by `pwr_up`.

## Interface
- `fast_sim`, default 1'b1: shortens the settle timer for simulation.
- `MIN_RIDER_WT`, default 13'h0200: minimum load sum for rider-present.
- `WT_HYSTERESIS`, default 13'h0040: hysteresis below `MIN_RIDER_WT` for rider-absent.
- `clk` input 1: system clock. One clock only.
- `rst_n` input 1: synchronous, active-low reset.
- `lft_ld` input 12: left load cell, unsigned.
- `rght_ld` input 12: right load cell, unsigned.
- `ld_vld` input 1: single-cycle strobe; both loads are valid this cycle.
- `pwr_up` input 1: system powered. Low forces IDLE.
- `too_fast` input 1: overspeed flag from SegwayMath.
- `rider_off` output 1: high when no qualified rider is present.
- `en_steer` output 1: steering enable.
- `seq_state` output 2: current state encoding, for debug and the bench.

## Operation
- **Load capture:** `lft_ld` and `rght_ld` are registered into `lft_q`/`rght_q` on cycles where `ld_vld` is high. The registers hold otherwise. Reset value is 0.
- **Derived quantities:** all 13-bit unsigned, combinational from the captured loads.
  - `sum = lft_q + rght_q`
  - `diff = |lft_q - rght_q|`
- **Flags:**
  - `sum_gt_min = sum > MIN_RIDER_WT`
  - `sum_lt_min = sum < MIN_RIDER_WT - WT_HYSTERESIS`
  - `diff_gt_1_4 = diff > (sum >> 2)`
  - `diff_gt_15_16 = diff > (sum - (sum >> 4))`
- **Settle timer:**
  - Width is 26 bits when `fast_sim`=0 (about 1.34 s at 50 MHz) and 15 bits when `fast_sim`=1.
  - Increments every cycle and wraps at all-ones.
  - Synchronous clear has priority over increment.
  - `tmr_full` is true when the timer equals all-ones.
- **States** (encoded in `seq_state`): IDLE=2'b00, WAIT=2'b01, STEER=2'b10. Encoding 2'b11 is illegal and recovers to IDLE on the next clock.
- **Transitions:** priority is top to bottom within each state. Evaluation happens every clock, not only on `ld_vld`.
  - Any state, `!pwr_up`: go to IDLE, clear timer.
  - IDLE: if `sum_gt_min`, go to WAIT and clear timer.
  - WAIT: if `sum_lt_min`, go to IDLE. Else if `diff_gt_1_4`, stay in WAIT and clear timer. Else if `tmr_full`, go to STEER. Else stay and count.
  - STEER: if `sum_lt_min`, go to IDLE. Else if `diff_gt_15_16`, go to WAIT and clear timer. Else stay.
- **Outputs:** decoded from the state register only (Moore), so they are glitch-free.
  - `rider_off` = (state==IDLE).
  - `en_steer` = (state==STEER).
- **Simultaneous events:** `!pwr_up` overrides all other conditions. Within a state, the rider-leaving check (`sum_lt_min`) is evaluated before any imbalance check.
- **Hysteresis band:** when `sum` lies between `MIN_RIDER_WT - WT_HYSTERESIS` and `MIN_RIDER_WT` inclusive, the current state is held with no change.

## Timing
- **Reset:** state IDLE, `lft_q`/`rght_q` = 0, timer = 0. Outputs at reset: `rider_off`=1, `en_steer`=0, `seq_state`=2'b00.
- **Load-to-output latency:** from the clock edge sampling `ld_vld`, a state or output change occurs exactly 2 clocks later (1 clock capture, 1 clock state update).
- **WAIT-to-STEER delay:** with `fast_sim`=1 and stable balanced loads, STEER is entered 32768 clocks after entering WAIT. That is 32767 increments to full, then one transition clock.
- **`pwr_up` fall:** IDLE is reached on the next clock edge.
- **Reset mid-operation:** returns to the full reset state on the next edge, and the timer restarts from 0.

## Configuration
- Macro: `RIDER_SEQ_TOO_FAST_LOCKOUT_EN`.
- **Defined:** in STEER, `too_fast`=1 forces STEER→WAIT with the timer cleared. This check has priority just below `sum_lt_min`. Re-entry to STEER requires a full settle period with `too_fast` low; any cycle with `too_fast` high in WAIT clears the timer.
- **Undefined:** `too_fast` is ignored. The port remains present.

## Structure
- **Shared package `rider_seq_pkg`:**
  - `seq_state_t` enum (IDLE/WAIT/STEER).
  - Timer width constants `TMR_W_FAST`=15 and `TMR_W_FULL`=26.
  - Default threshold localparams.
- **Sub-module `settle_tmr`:** parameterised width, with `clr`, `cnt` wraparound, and a `full` output. It is instantiated once.

## Test plan
- **Reset:** reset asserted → `rider_off`=1, `en_steer`=0, `seq_state`=0. A load of 12'h300/12'h300 with `pwr_up`=0 stays in IDLE.
- **Normal mount:** `pwr_up`=1 and `ld_vld` pulse with `lft_ld`=12'h200, `rght_ld`=12'h1F0. WAIT is entered 2 clocks later, and `en_steer`=1 exactly 32768 clocks after WAIT entry (`fast_sim`=1).
- **Imbalance restart:** in WAIT at timer count 20000, load 12'h380/12'h080 (diff 0x300 > sum/4 0x100). The timer clears. Restoring balance then needs another 32768 clocks to reach STEER.
- **Dismount and hysteresis:** in STEER, loads of 12'h0E0/12'h0E0 (sum 0x1C0, in band) keep STEER. Loads of 12'h0D0/12'h0D0 (sum 0x1A0 < 0x1C0) go to IDLE and `rider_off`=1 two clocks after `ld_vld`.
- **Step-off one side:** in STEER, loads of 12'h3F0/12'h010 (diff 0x3E0 > 15/16 sum 0x3C0) go to WAIT with `en_steer`=0.
- **Lockout and power-down:** with `RIDER_SEQ_TOO_FAST_LOCKOUT_EN` defined, `too_fast`=1 in STEER goes to WAIT on the next clock; without the macro, STEER is held. Separately, `pwr_up` falling in STEER gives IDLE on the next edge.

Source files
------------

// File: rtl/rider_seq_pkg.sv
// -----------------------------------------------------------------------------
// rider_seq_pkg
// Shared types and constants for the rider-detection / steering-enable
// sequencer.
//   seq_state_t        : sequencer state encoding (IDLE/WAIT/STEER)
//   TMR_W_FAST/FULL    : settle timer widths for simulation / silicon builds
//   *_DEF              : default load thresholds
//   ld_abs_diff()      : 13-bit |a - b| of two 12-bit unsigned loads
// -----------------------------------------------------------------------------
package rider_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    STEER = 2'b10
  } seq_state_t;

  // 2^15 clocks is enough to watch a full settle in simulation; 2^26 clocks
  // is ~1.34 s at 50 MHz for the real platform.
  localparam int TMR_W_FAST = 15;
  localparam int TMR_W_FULL = 26;

  localparam logic [12:0] MIN_RIDER_WT_DEF  = 13'h0200;
  localparam logic [12:0] WT_HYSTERESIS_DEF = 13'h0040;

  function automatic logic [12:0] ld_abs_diff(input logic [11:0] a,
                                              input logic [11:0] b);
    logic [11:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return {1'b0, d};
  endfunction

endpackage

// File: rtl/rider_sequencer_settle_tmr.sv
// -----------------------------------------------------------------------------
// settle_tmr
// Free-running settle timer with synchronous clear.
//   clk   in  : system clock
//   rst_n in  : synchronous active-low reset (timer -> 0)
//   clr   in  : synchronous clear, wins over inc
//   inc   in  : count enable; counter wraps from all-ones to zero
//   full  out : timer currently holds all-ones
// -----------------------------------------------------------------------------
module settle_tmr #(
  parameter int W = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic full
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 1'b1;  // natural wrap at all-ones
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign full = &cnt_q;

endmodule

// File: rtl/rider_sequencer.sv
// -----------------------------------------------------------------------------
// rider_sequencer
// Qualifies the two load-cell readings and sequences rider_off / en_steer
// for the balance controller (IDLE -> WAIT -> STEER with a settle timer).
//
// Parameters
//   fast_sim      : 1 = 15-bit settle timer, 0 = 26-bit settle timer
//   MIN_RIDER_WT  : load sum strictly above this means a rider stepped on
//   WT_HYSTERESIS : rider is gone when sum < MIN_RIDER_WT - WT_HYSTERESIS
// Ports
//   clk, rst_n    : clock, synchronous active-low reset
//   lft_ld/rght_ld: 12-bit unsigned load cells, captured when ld_vld is high
//   ld_vld        : single-cycle strobe, both loads valid
//   pwr_up        : low forces IDLE
//   too_fast      : overspeed flag (only used with the lockout macro)
//   rider_off     : registered, high in IDLE
//   en_steer      : registered, high in STEER
//   seq_state     : current state encoding
//
// Build option
//   RIDER_SEQ_TOO_FAST_LOCKOUT_EN : when defined, too_fast drops STEER back
//   to WAIT and holds the settle timer cleared while in WAIT. When undefined
//   too_fast is ignored (port kept for a stable interface).
// -----------------------------------------------------------------------------
module rider_sequencer
  import rider_seq_pkg::*;
#(
  parameter logic        fast_sim      = 1'b1,
  parameter logic [12:0] MIN_RIDER_WT  = MIN_RIDER_WT_DEF,
  parameter logic [12:0] WT_HYSTERESIS = WT_HYSTERESIS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic        ld_vld,
  input  logic        pwr_up,
  input  logic        too_fast,
  output logic        rider_off,
  output logic        en_steer,
  output logic [1:0]  seq_state
);

  localparam int          TMR_W     = fast_sim ? TMR_W_FAST : TMR_W_FULL;
  localparam logic [12:0] LEAVE_THR = MIN_RIDER_WT - WT_HYSTERESIS;

  // ---------------------------------------------------------------------------
  // Load capture
  // ---------------------------------------------------------------------------
  logic [11:0] lft_q, lft_d;
  logic [11:0] rght_q, rght_d;

  always_comb begin
    lft_d  = lft_q;
    rght_d = rght_q;
    if (ld_vld) begin
      lft_d  = lft_ld;
      rght_d = rght_ld;
    end
  end

  // ---------------------------------------------------------------------------
  // Derived quantities and flags (from captured loads only, so a new sample
  // affects the state one clock after it is captured)
  // ---------------------------------------------------------------------------
  logic [12:0] sum, diff;
  logic        sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;

  assign sum  = {1'b0, lft_q} + {1'b0, rght_q};
  assign diff = ld_abs_diff(lft_q, rght_q);

  assign sum_gt_min    = sum > MIN_RIDER_WT;
  assign sum_lt_min    = sum < LEAVE_THR;
  assign diff_gt_1_4   = diff > (sum >> 2);
  // sum - sum/16 never underflows, so 13 bits are sufficient.
  assign diff_gt_15_16 = diff > (sum - (sum >> 4));

  // ---------------------------------------------------------------------------
  // Overspeed lockout
  // ---------------------------------------------------------------------------
  logic lockout;

`ifdef RIDER_SEQ_TOO_FAST_LOCKOUT_EN
  assign lockout = too_fast;
`else
  logic unused_too_fast;
  assign unused_too_fast = too_fast;
  assign lockout         = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Settle timer
  // ---------------------------------------------------------------------------
  logic tmr_clr, tmr_full;

  settle_tmr #(.W(TMR_W)) u_settle_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .inc   (1'b1),
    .full  (tmr_full)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  seq_state_t state_q, state_d;
  logic       rider_off_q, rider_off_d;
  logic       en_steer_q, en_steer_d;

  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    if (!pwr_up) begin
      state_d = IDLE;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (sum_gt_min) begin
            state_d = WAIT;
            tmr_clr = 1'b1;
          end
        end
        WAIT: begin
          // Rider leaving is checked before imbalance; any imbalance (or
          // overspeed with lockout) restarts the settle period.
          if (sum_lt_min)                   state_d = IDLE;
          else if (diff_gt_1_4 || lockout)  tmr_clr = 1'b1;
          else if (tmr_full)                state_d = STEER;
        end
        STEER: begin
          if (sum_lt_min) begin
            state_d = IDLE;
          end else if (lockout || diff_gt_15_16) begin
            state_d = WAIT;
            tmr_clr = 1'b1;
          end
        end
        default: state_d = IDLE;  // 2'b11 recovers on the next clock
      endcase
    end
    // Outputs are registered alongside the state so they always equal a
    // decode of the state register and never glitch.
    rider_off_d = (state_d == IDLE);
    en_steer_d  = (state_d == STEER);
  end

  // ---------------------------------------------------------------------------
  // State, capture and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lft_q       <= '0;
      rght_q      <= '0;
      rider_off_q <= 1'b1;
      en_steer_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lft_q       <= lft_d;
      rght_q      <= rght_d;
      rider_off_q <= rider_off_d;
      en_steer_q  <= en_steer_d;
    end
  end

  assign rider_off = rider_off_q;
  assign en_steer  = en_steer_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_rider_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rider_sequencer
// Several independent sequencer instances share one clock so the long settle
// periods of the different scenarios overlap in time. A per-lane reference
// model tracks the expected state from the rider rules directly.
// -----------------------------------------------------------------------------
module tb_rider_sequencer;

  localparam int NL     = 5;
  localparam int MIN_WT = 'h200;
  localparam int HYS    = 'h40;
  localparam int SETTLE = (1 << 15) - 1;  // timer value at which WAIT may leave

`ifdef RIDER_SEQ_TOO_FAST_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NL-1:0][11:0]   lft_ld, rght_ld;
  logic [NL-1:0]         ld_vld, pwr_up, too_fast;
  logic [NL-1:0]         rider_off, en_steer;
  logic [NL-1:0][1:0]    seq_state;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    rider_sequencer #(
      .fast_sim      (1'b1),
      .MIN_RIDER_WT  (13'h0200),
      .WT_HYSTERESIS (13'h0040)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .lft_ld    (lft_ld[g]),
      .rght_ld   (rght_ld[g]),
      .ld_vld    (ld_vld[g]),
      .pwr_up    (pwr_up[g]),
      .too_fast  (too_fast[g]),
      .rider_off (rider_off[g]),
      .en_steer  (en_steer[g]),
      .seq_state (seq_state[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Reference model: st 0=no rider, 1=settling, 2=steering; n = clocks the
  // rider has been settled (only meaningful while settling).
  // ---------------------------------------------------------------------------
  int m_l[NL], m_r[NL], m_st[NL], m_n[NL];

  initial begin
    for (int i = 0; i < NL; i++) begin
      m_l[i] = 0; m_r[i] = 0; m_st[i] = 0; m_n[i] = 0;
    end
  end

  always @(posedge clk) begin : model
    int s, d, ns, nn;
    for (int i = 0; i < NL; i++) begin
      s  = m_l[i] + m_r[i];
      d  = (m_l[i] > m_r[i]) ? m_l[i] - m_r[i] : m_r[i] - m_l[i];
      ns = m_st[i];
      nn = m_n[i] + 1;
      if (!pwr_up[i]) begin
        ns = 0;
      end else if (m_st[i] == 0) begin
        if (s > MIN_WT) begin ns = 1; nn = 0; end
      end else if (m_st[i] == 1) begin
        if (s < MIN_WT - HYS)                         ns = 0;
        else if (d > s / 4 || (LOCKOUT && too_fast[i])) nn = 0;
        else if (m_n[i] == SETTLE)                    ns = 2;
      end else begin
        if (s < MIN_WT - HYS) ns = 0;
        else if ((LOCKOUT && too_fast[i]) || d > s - s / 16) begin ns = 1; nn = 0; end
      end
      if (!rst_n) begin
        m_st[i] <= 0; m_n[i] <= 0; m_l[i] <= 0; m_r[i] <= 0;
      end else begin
        m_st[i] <= ns;
        m_n[i]  <= nn;
        if (ld_vld[i]) begin
          m_l[i] <= int'(lft_ld[i]);
          m_r[i] <= int'(rght_ld[i]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("%s seq_state lane%0d", tag, i), 32'(seq_state[i]), 32'(m_st[i]));
      chk($sformatf("%s rider_off lane%0d", tag, i), 32'(rider_off[i]), 32'(m_st[i] == 0));
      chk($sformatf("%s en_steer lane%0d", tag, i),  32'(en_steer[i]),  32'(m_st[i] == 2));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      if (k % 4096 == 4095) check_all("run");
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n    = 1'b0;
    ld_vld   = '0;
    pwr_up   = '0;
    too_fast = '0;
    for (int i = 0; i < NL; i++) begin lft_ld[i] = '0; rght_ld[i] = '0; end

    // Reset state
    tick(); tick();
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("reset rider_off lane%0d", i), 32'(rider_off[i]), 32'd1);
      chk($sformatf("reset en_steer lane%0d", i),  32'(en_steer[i]),  32'd0);
      chk($sformatf("reset seq_state lane%0d", i), 32'(seq_state[i]), 32'd0);
    end
    rst_n = 1'b1;

    // Heavy load while powered down stays in IDLE
    for (int i = 0; i < NL; i++) begin lft_ld[i] = 12'h300; rght_ld[i] = 12'h300; end
    ld_vld = '1;
    tick();
    ld_vld = '0;
    tick(); tick(); tick();
    for (int i = 0; i < NL; i++)
      chk($sformatf("pwr_down hold lane%0d", i), 32'(seq_state[i]), 32'd0);
    check_all("pwr_down");

    // Reset clears the captured loads: powering up afterwards must not mount
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    pwr_up = '1;
    tick(); tick(); tick();
    for (int i = 0; i < NL; i++)
      chk($sformatf("reset clears loads lane%0d", i), 32'(seq_state[i]), 32'd0);

    // Normal mount on every lane
    for (int i = 0; i < NL; i++) begin lft_ld[i] = 12'h200; rght_ld[i] = 12'h1F0; end
    ld_vld = '1;
    tick();                              // capture edge
    ld_vld = '0;
    chk("mount latency1 lane0", 32'(seq_state[0]), 32'd0);
    tick();                              // t=0: WAIT entered
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("mount wait lane%0d", i),      32'(seq_state[i]), 32'd1);
      chk($sformatf("mount rider_on lane%0d", i),  32'(rider_off[i]), 32'd0);
    end
    check_all("mount");

    // Lane 0: imbalance at timer count 20000
    run(20000);                          // t=20000
    ld_vld[0] = 1'b1; lft_ld[0] = 12'h380; rght_ld[0] = 12'h080;
    tick();                              // t=20001 capture
    ld_vld = '0;
    tick();                              // t=20002 timer cleared
    chk("imbalance stays wait", 32'(seq_state[0]), 32'd1);
    ld_vld[0] = 1'b1; lft_ld[0] = 12'h200; rght_ld[0] = 12'h1F0;
    tick();                              // t=20003: last clear, balance captured
    ld_vld = '0;

    // Lanes 1..4 reach STEER exactly 32768 clocks after WAIT entry
    run(32767 - 20003);                  // t=32767
    for (int i = 1; i < NL; i++)
      chk($sformatf("pre steer lane%0d", i), 32'(en_steer[i]), 32'd0);
    tick();                              // t=32768
    for (int i = 1; i < NL; i++)
      chk($sformatf("steer entry lane%0d", i), 32'(en_steer[i]), 32'd1);
    chk("lane0 restart still wait", 32'(seq_state[0]), 32'd1);
    check_all("steer entry");

    // In STEER: band hold (1), step-off (2), overspeed (3), power-down (4)
    ld_vld[1] = 1'b1; lft_ld[1] = 12'h0E0; rght_ld[1] = 12'h0E0;
    ld_vld[2] = 1'b1; lft_ld[2] = 12'h3F0; rght_ld[2] = 12'h010;
    too_fast[3] = 1'b1;
    pwr_up[4]   = 1'b0;
    tick();
    ld_vld = '0; too_fast = '0;
    chk("lockout next clock", 32'(seq_state[3]), LOCKOUT ? 32'd1 : 32'd2);
    chk("pwr fall idle", 32'(seq_state[4]), 32'd0);
    chk("pwr fall rider_off", 32'(rider_off[4]), 32'd1);
    chk("stepoff latency1", 32'(seq_state[2]), 32'd2);
    tick();
    chk("stepoff wait", 32'(seq_state[2]), 32'd1);
    chk("stepoff en_steer", 32'(en_steer[2]), 32'd0);
    chk("band hold steer", 32'(seq_state[1]), 32'd2);
    ld_vld[1] = 1'b1; lft_ld[1] = 12'h0D0; rght_ld[1] = 12'h0D0;
    tick();
    ld_vld = '0;
    chk("dismount latency1", 32'(rider_off[1]), 32'd0);
    tick();
    chk("dismount rider_off", 32'(rider_off[1]), 32'd1);
    chk("dismount en_steer", 32'(en_steer[1]), 32'd0);
    check_all("steer exits");

    // Lane 0 reaches STEER 32768 clocks after balance was restored (t=20003)
    run(52770 - 32772);                  // t=52770
    chk("restart pre steer", 32'(en_steer[0]), 32'd0);
    tick();                              // t=52771
    chk("restart steer", 32'(en_steer[0]), 32'd1);
    check_all("restart");

    // Randomized loads near the thresholds, every lane, checked every clock
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NL; i++) begin
        int b, l, r;
        b = $urandom_range('h80, 'h140);
        case ($urandom_range(0, 3))
          0: begin l = b; r = b; end
          1: begin l = b; r = b + $urandom_range(0, 'h60) - 'h30; end
          2: begin l = 2 * b; r = $urandom_range(0, 'h40); end
          default: begin l = $urandom_range(0, 4095); r = $urandom_range(0, 4095); end
        endcase
        ld_vld[i]   = ($urandom_range(0, 3) == 0);
        lft_ld[i]   = 12'(l);
        rght_ld[i]  = 12'(r);
        too_fast[i] = ($urandom_range(0, 15) == 0);
        pwr_up[i]   = ($urandom_range(0, 63) != 0);
      end
      tick();
      check_all("random");
    end

    // Reset mid-operation with heavy loads captured while powered down
    for (int i = 0; i < NL; i++) begin lft_ld[i] = 12'h300; rght_ld[i] = 12'h300; end
    ld_vld = '1; pwr_up = '0; too_fast = '0;
    tick();
    ld_vld = '0;
    rst_n  = 1'b0;
    tick();
    for (int i = 0; i < NL; i++)
      chk($sformatf("midop reset lane%0d", i), 32'(rider_off[i]), 32'd1);
    rst_n  = 1'b1;
    pwr_up = '1;
    tick(); tick();
    for (int i = 0; i < NL; i++)
      chk($sformatf("midop loads cleared lane%0d", i), 32'(seq_state[i]), 32'd0);
    check_all("midop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
